// File: rtl/spi_pwm_pkg.sv
// Shared constants, register-map decode and frame receiver state type for the SPI PWM bank.
package spi_pwm_pkg;

  localparam logic [6:0] ADDR_ID        = 7'h00;
  localparam logic [6:0] ADDR_CTRL_BASE = 7'h10;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h40;
  localparam logic [7:0] ID_VALUE       = 8'hA5;
  localparam int         FRAME_BITS     = 16;
  localparam logic [7:0] PWM_TOP        = 8'd254;

  typedef enum logic [1:0] {
    FR_WAIT_IDLE,
    FR_IDLE,
    FR_ACTIVE
  } frame_state_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ID,
    REG_CTRL,
    REG_DUTY
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [4:0] ch;
  } reg_sel_t;

  // Channels at or beyond num_ch decode as REG_NONE so they read 0 and ignore writes.
  function automatic reg_sel_t decode_addr(input logic [6:0] addr, input int num_ch);
    reg_sel_t sel;
    int a;
    a = int'(addr);
    sel.kind = REG_NONE;
    sel.ch = '0;
    if (addr == ADDR_ID) begin
      sel.kind = REG_ID;
    end else if (a >= int'(ADDR_CTRL_BASE) && a < int'(ADDR_CTRL_BASE) + num_ch) begin
      sel.kind = REG_CTRL;
      sel.ch = 5'(a - int'(ADDR_CTRL_BASE));
    end else if (a >= int'(ADDR_DUTY_BASE) && a < int'(ADDR_DUTY_BASE) + num_ch) begin
      sel.kind = REG_DUTY;
      sel.ch = 5'(a - int'(ADDR_DUTY_BASE));
    end
    return sel;
  endfunction

endpackage

// File: rtl/spi_pwm_frame_rx.sv
// SPI mode-0 frame receiver: synchronisers, edge detection, 16-bit shifter and CIPO serialiser.
module spi_pwm_frame_rx
  import spi_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       wr_valid,
  output logic [6:0] addr,
  output logic [7:0] wdata,
  output logic       rd_strobe,
  output logic [6:0] rd_addr,
  input  logic [7:0] rd_data
);

  logic [2:0] sclk_pipe;
  logic [2:0] ncs_pipe;
  logic [1:0] copi_pipe;
  logic [1:0] settle;
  logic [15:0] shift;
  logic [4:0] bit_cnt;
  logic rd_pend;
  logic is_read;
  logic [7:0] rd_buf;
  frame_state_e state, state_next;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic frame_start, frame_end, shift_en, fall_en;

  assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
  assign sclk_fall = ~sclk_pipe[1] & sclk_pipe[2];
  assign ncs_rise  = ncs_pipe[1] & ~ncs_pipe[2];
  assign ncs_fall  = ~ncs_pipe[1] & ncs_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= 3'b000;
      ncs_pipe  <= 3'b111;
      copi_pipe <= 2'b00;
      settle    <= 2'd0;
      state     <= FR_WAIT_IDLE;
    end else begin
      sclk_pipe <= {sclk_pipe[1:0], sclk};
      ncs_pipe  <= {ncs_pipe[1:0], ncs};
      copi_pipe <= {copi_pipe[0], copi};
      if (settle != 2'd3) settle <= settle + 2'd1;
      state <= state_next;
    end
  end

  // After reset the nCS pipeline must show a real high level before a falling
  // edge can open a frame, so a frame cut by reset cannot resume.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    shift_en    = 1'b0;
    fall_en     = 1'b0;
    case (state)
      FR_WAIT_IDLE: if (settle == 2'd3 && ncs_pipe[1]) state_next = FR_IDLE;
      FR_IDLE: begin
        if (ncs_fall) begin
          state_next  = FR_ACTIVE;
          frame_start = 1'b1;
        end
      end
      FR_ACTIVE: begin
        if (ncs_rise) begin
          state_next = FR_IDLE;
          frame_end  = 1'b1;
        end else begin
          shift_en = sclk_rise & ~ncs_pipe[1];
          fall_en  = sclk_fall;
        end
      end
      default: state_next = FR_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      bit_cnt  <= '0;
      wr_valid <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rd_pend  <= 1'b0;
      is_read  <= 1'b0;
      rd_buf   <= '0;
      cipo     <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_pend  <= 1'b0;
      if (frame_start) begin
        shift   <= '0;
        bit_cnt <= '0;
        is_read <= 1'b0;
        cipo    <= 1'b0;
      end else if (frame_end) begin
        wr_valid <= (bit_cnt == 5'(FRAME_BITS)) && shift[15];
        addr     <= shift[14:8];
        wdata    <= shift[7:0];
        is_read  <= 1'b0;
        cipo     <= 1'b0;
      end else begin
        if (shift_en) begin
          shift <= {shift[14:0], copi_pipe[1]};
          if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7 && !shift[6]) rd_pend <= 1'b1;
        end
        if (rd_pend) begin
          rd_buf  <= rd_data;
          is_read <= 1'b1;
        end
        // Bit counts 8..15 map to data bits 7..0 on the following falling edges.
        if (fall_en) begin
          cipo <= (is_read && bit_cnt[4:3] == 2'b01) ? rd_buf[~bit_cnt[2:0]] : 1'b0;
        end
      end
    end
  end

  assign rd_strobe = rd_pend;
  assign rd_addr   = shift[6:0];

endmodule

// File: rtl/spi_pwm_bank.sv
// Bank of SPI-programmable PWM channels with double-buffered duty and a shared period counter.
module spi_pwm_bank #(
  parameter int NUM_CH   = 16,
  parameter int PRESCALE = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              COPI,
  input  logic              nCS,
  output logic              CIPO,
  output logic [NUM_CH-1:0] pwm_out
);
  import spi_pwm_pkg::*;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wdata;
  logic       rd_strobe;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  reg_sel_t   wr_sel, rd_sel;

  logic [1:0] ctrl   [NUM_CH];
  logic [7:0] shadow [NUM_CH];
  logic [7:0] active [NUM_CH];
  logic [PS_W-1:0] ps_cnt;
  logic [7:0] period_cnt;
  logic tick;

  spi_pwm_frame_rx u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (SCLK),
    .copi     (COPI),
    .ncs      (nCS),
    .cipo     (CIPO),
    .wr_valid (wr_valid),
    .addr     (wr_addr),
    .wdata    (wdata),
    .rd_strobe(rd_strobe),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  assign wr_sel = decode_addr(wr_addr, NUM_CH);
  assign rd_sel = decode_addr(rd_addr, NUM_CH);

  always_comb begin
    rd_data = '0;
    if (rd_strobe) begin
      case (rd_sel.kind)
        REG_ID: rd_data = ID_VALUE;
        REG_CTRL: begin
          for (int i = 0; i < NUM_CH; i++)
            if (rd_sel.ch == 5'(i)) rd_data = {6'b0, ctrl[i]};
        end
        REG_DUTY: begin
          for (int i = 0; i < NUM_CH; i++)
            if (rd_sel.ch == 5'(i)) rd_data = shadow[i];
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt     <= '0;
      period_cnt <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
      if (tick) period_cnt <= (period_cnt == PWM_TOP) ? 8'd0 : period_cnt + 8'd1;
    end
  end

  // Active duty only reloads at the wrap tick, so a period never changes shape midway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl[i]    <= '0;
        shadow[i]  <= '0;
        active[i]  <= '0;
        pwm_out[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_valid && wr_sel.kind == REG_CTRL && wr_sel.ch == 5'(i)) ctrl[i] <= wdata[1:0];
        if (wr_valid && wr_sel.kind == REG_DUTY && wr_sel.ch == 5'(i)) shadow[i] <= wdata;
        if (tick && period_cnt == PWM_TOP) active[i] <= shadow[i];
        if (!ctrl[i][0])      pwm_out[i] <= 1'b0;
        else if (!ctrl[i][1]) pwm_out[i] <= 1'b1;
        else                  pwm_out[i] <= (period_cnt < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Directed self-checking bench for spi_pwm_bank with a small channel count and fast prescaler.
module tb_spi_pwm_bank;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 4;
  localparam int HALF     = 5;
  localparam int PERIOD   = 255 * PRESCALE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SCLK = 1'b0;
  logic COPI = 1'b0;
  logic nCS = 1'b1;
  logic CIPO;
  logic [NUM_CH-1:0] pwm_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spi_pwm_bank #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SCLK   (SCLK),
    .COPI   (COPI),
    .nCS    (nCS),
    .CIPO   (CIPO),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic spi_start();
    nCS = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input int nbits, input logic [16:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      COPI = tx[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], CIPO};
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    nCS = 1'b1;
    COPI = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] unused_rx;
    spi_start();
    spi_bits(16, {1'b0, 1'b1, a, d}, unused_rx);
    spi_end();
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
    spi_start();
    spi_bits(16, {1'b0, 1'b0, a, 8'h00}, d);
    spi_end();
  endtask

  task automatic wait_pwm(input int ch, input logic level, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pwm_out[ch] == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_pwm actual=%b required=%b", pwm_out, 4'b0000);
    end
    checks++;
    if (CIPO !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cipo actual=%b required=0", CIPO);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ctrl_static();
    logic [7:0] d;
    int lows, others;
    spi_write(7'h10, 8'h01);
    spi_read(7'h10, d);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("[TB] FAIL ctrl0_readback actual=%h required=01", d);
    end
    lows = 0;
    others = 0;
    for (int i = 0; i < PERIOD + 80; i++) begin
      @(negedge clk);
      if (pwm_out[0] !== 1'b1) lows++;
      if (pwm_out[3:1] !== 3'b000) others++;
    end
    checks++;
    if (lows != 0) begin
      failures++;
      $display("[TB] FAIL ctrl0_constant_high low_cycles=%0d required=0", lows);
    end
    checks++;
    if (others != 0) begin
      failures++;
      $display("[TB] FAIL other_channels_low active_cycles=%0d required=0", others);
    end
  endtask

  task automatic test_duty_half();
    logic ok1, ok2, ok3;
    int t0, t1, t2;
    logic [7:0] d;
    spi_write(7'h11, 8'h03);
    spi_write(7'h41, 8'h80);
    wait_pwm(1, 1'b1, 2 * PERIOD + 200, ok1);
    t0 = cyc;
    wait_pwm(1, 1'b0, PERIOD, ok2);
    t1 = cyc;
    wait_pwm(1, 1'b1, PERIOD, ok3);
    t2 = cyc;
    checks++;
    if (!(ok1 && ok2) || (t1 - t0) != 128 * PRESCALE) begin
      failures++;
      $display("[TB] FAIL duty80_high_cycles actual=%0d required=%0d ok=%b%b", t1 - t0, 128 * PRESCALE, ok1, ok2);
    end
    checks++;
    if (!ok3 || (t2 - t1) != 127 * PRESCALE) begin
      failures++;
      $display("[TB] FAIL duty80_low_cycles actual=%0d required=%0d ok=%b", t2 - t1, 127 * PRESCALE, ok3);
    end
    spi_read(7'h41, d);
    checks++;
    if (d !== 8'h80) begin
      failures++;
      $display("[TB] FAIL duty1_readback actual=%h required=80", d);
    end
    spi_read(7'h11, d);
    checks++;
    if (d !== 8'h03) begin
      failures++;
      $display("[TB] FAIL ctrl1_readback actual=%h required=03", d);
    end
  endtask

  task automatic test_duty_extremes();
    int ch2_high, ch3_low, ch0_low;
    spi_write(7'h12, 8'h03);
    spi_write(7'h42, 8'h00);
    spi_write(7'h13, 8'h03);
    spi_write(7'h43, 8'hFF);
    repeat (PERIOD + 80) @(negedge clk);
    ch2_high = 0;
    ch3_low = 0;
    ch0_low = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (pwm_out[2] !== 1'b0) ch2_high++;
      if (pwm_out[3] !== 1'b1) ch3_low++;
      if (pwm_out[0] !== 1'b1) ch0_low++;
    end
    checks++;
    if (ch2_high != 0) begin
      failures++;
      $display("[TB] FAIL duty00_constant_low high_cycles=%0d required=0", ch2_high);
    end
    checks++;
    if (ch3_low != 0) begin
      failures++;
      $display("[TB] FAIL dutyFF_constant_high low_cycles=%0d required=0", ch3_low);
    end
    checks++;
    if (ch0_low != 0) begin
      failures++;
      $display("[TB] FAIL ch0_still_high low_cycles=%0d required=0", ch0_low);
    end
  endtask

  task automatic test_mid_period();
    logic ok1, ok2, ok3, ok4;
    int t0, t1, t2, t3;
    spi_write(7'h42, 8'h40);
    wait_pwm(2, 1'b1, 2 * PERIOD + 200, ok1);
    t0 = cyc;
    spi_write(7'h42, 8'hC0);
    wait_pwm(2, 1'b0, PERIOD, ok2);
    t1 = cyc;
    wait_pwm(2, 1'b1, PERIOD, ok3);
    t2 = cyc;
    wait_pwm(2, 1'b0, PERIOD, ok4);
    t3 = cyc;
    checks++;
    if (!(ok1 && ok2) || (t1 - t0) != 64 * PRESCALE) begin
      failures++;
      $display("[TB] FAIL midperiod_current_high actual=%0d required=%0d ok=%b%b", t1 - t0, 64 * PRESCALE, ok1, ok2);
    end
    checks++;
    if (!(ok3 && ok4) || (t3 - t2) != 192 * PRESCALE) begin
      failures++;
      $display("[TB] FAIL midperiod_next_high actual=%0d required=%0d ok=%b%b", t3 - t2, 192 * PRESCALE, ok3, ok4);
    end
  endtask

  task automatic test_bad_frames();
    logic [7:0] d;
    logic [7:0] unused_rx;
    spi_start();
    spi_bits(15, 17'h04800, unused_rx);
    spi_end();
    spi_read(7'h10, d);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("[TB] FAIL frame15_ignored actual=%h required=01", d);
    end
    spi_start();
    spi_bits(17, 17'h12000, unused_rx);
    spi_end();
    spi_read(7'h10, d);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("[TB] FAIL frame17_ignored actual=%h required=01", d);
    end
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bad_frames_pwm0 actual=%b required=1", pwm_out[0]);
    end
    spi_write(7'h00, 8'h00);
    spi_read(7'h00, d);
    checks++;
    if (d !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL id_read actual=%h required=a5", d);
    end
    spi_read(7'h7F, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL read_7f actual=%h required=00", d);
    end
    spi_read(7'h14, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL read_ctrl_out_of_range actual=%h required=00", d);
    end
    spi_write(7'h44, 8'h55);
    spi_read(7'h44, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL write_duty_out_of_range actual=%h required=00", d);
    end
    checks++;
    if (CIPO !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cipo_idle actual=%b required=0", CIPO);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic [7:0] unused_rx;
    spi_start();
    spi_bits(9, 17'h00120, unused_rx);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 4'b0000 || CIPO !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midframe_reset_outputs actual=%b/%b required=0000/0", pwm_out, CIPO);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (pwm_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL after_reset_outputs actual=%b required=0000", pwm_out);
    end
    spi_end();
    spi_write(7'h11, 8'h01);
    checks++;
    if (pwm_out !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL post_reset_commit actual=%b required=0010", pwm_out);
    end
    spi_read(7'h10, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL ctrl0_cleared actual=%h required=00", d);
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_ctrl_static();
    test_duty_half();
    test_duty_extremes();
    test_mid_period();
    test_bad_frames();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_pwm_bank.md
SPI_PWM_BANK -- requirements
Module: spi_pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 16, range 1..32: number of PWM channels.
REQ-002 Parameter PRESCALE, default 3000, min 1: clk cycles per PWM counter tick.
REQ-003 Port clk, input, 1, single system clock; all state is in this domain.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port SCLK, input, 1, SPI clock, asynchronous to clk.
REQ-006 Port COPI, input, 1, SPI controller-out data, asynchronous to clk.
REQ-007 Port nCS, input, 1, SPI chip select, active low, asynchronous to clk.
REQ-008 Port CIPO, output, 1, SPI read data.
REQ-009 Port pwm_out, output, NUM_CH, per-channel output.

Function
REQ-010 SCLK, COPI and nCS SHALL each pass a 2-flop synchroniser; edges SHALL be detected on the synchronised signals.
REQ-011 Frame: SPI mode 0, 16 bits, MSB first; bit15 = 1 write / 0 read, bits14:8 address, bits7:0 data.
REQ-012 COPI SHALL be sampled on each detected SCLK rising edge while nCS is low; the bit counter SHALL saturate at 17.
REQ-013 nCS falling edge SHALL clear the shift register and bit counter.
REQ-014 On nCS rising edge, a write SHALL commit in the next clk cycle only if exactly 16 bits were received; any other count SHALL discard the frame.
REQ-015 Map: 0x00 ID, read-only 0xA5; 0x10+ch CTRL[ch] (bit0 out_en, bit1 pwm_en, bits7:2 read 0); 0x40+ch DUTY[ch]. Addresses for ch >= NUM_CH are invalid.
REQ-016 Writes to invalid or read-only addresses SHALL be ignored; reads of them SHALL return 0x00.
REQ-017 Read: after the 8th rising edge, the addressed value SHALL be latched; bits 7:0 SHALL be driven MSB first on CIPO, each bit updated on a detected SCLK falling edge; outside bits 7:0 of a read, CIPO SHALL be 0.
REQ-018 The prescaler SHALL count 0..PRESCALE-1 and emit a one-cycle tick at wrap.
REQ-019 The 8-bit period counter SHALL advance on each tick, count 0..254, and wrap to 0 (period 255 ticks).
REQ-020 Each channel SHALL hold a shadow duty register; a committed DUTY write SHALL update it immediately.
REQ-021 The active duty SHALL load from the shadow only on the tick where the counter wraps to 0, so there are no mid-period glitches.
REQ-022 pwm = (counter < active_duty). Duty 0x00 SHALL give constant low; duty 0xFF SHALL give constant high.
REQ-023 pwm_out[ch] SHALL be registered: 0 if out_en=0; 1 if out_en=1 and pwm_en=0; pwm if both are set.
REQ-024 A CTRL write SHALL take effect on pwm_out one cycle after commit, not waiting for period end.
REQ-025 nCS rising SHALL take priority over an SCLK edge in the same cycle; that edge SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously clear: synchronisers (nCS flops SHALL reset to 1), shift register, bit counter, prescaler, period counter, all CTRL, shadow and active duty registers, CIPO and pwm_out.
REQ-027 Reset mid-frame SHALL abandon the frame; the next frame SHALL only be accepted after a new nCS falling edge.

Structure
REQ-028 Package spi_pwm_pkg SHALL hold: address bases (ADDR_ID, ADDR_CTRL_BASE, ADDR_DUTY_BASE), ID value, FRAME_BITS=16, PWM_TOP=254.
REQ-029 One sub-module, spi_pwm_frame_rx, SHALL contain the synchroniser, edge detection, shift and count logic, and CIPO serialiser.
REQ-030 spi_pwm_frame_rx SHALL present {wr_valid, addr, wdata} and a read-address strobe; the register file and PWM logic SHALL stay in spi_pwm_bank.

Verification
REQ-031 Write 0x10=0x01 then read 0x10 -> CIPO returns 0x01; pwm_out[0]=1 constantly.
REQ-032 Write 0x11=0x03 and 0x41=0x80 -> pwm_out[1] high for 128 of 255 ticks per period.
REQ-033 DUTY 0x00 and 0xFF on enabled channels -> constant 0 and constant 1 across 3 full periods.
REQ-034 Change DUTY mid-period from 0x40 to 0xC0 -> current period keeps 64 high ticks; next period has 192.
REQ-035 15-bit and 17-bit write frames to 0x10 -> CTRL unchanged; read 0x00 -> 0xA5; read 0x7F -> 0x00.
REQ-036 Assert rst_n after 9 bits of a write frame -> all outputs 0; the following full frame commits correctly.
